// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its multiplier.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_AND = 3'd1,
    OP_OR  = 3'd2,
    OP_XOR = 3'd3,
    OP_SUB = 3'd4,
    OP_MUL = 3'd5
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] ILLEGAL_FILL = {MAX_WIDTH{1'b1}};

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: operand magnitudes latched on start, one partial product
// per busy cycle, sign fix-up and overflow applied to the final step.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             busy_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sign_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o,
  output logic             ofl_o
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_step_s;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, prod_lo_s;
  logic               neg_q, neg_d, sgn_q, sgn_d;

  // Operand magnitudes; the most negative value maps onto its own unsigned pattern.
  always_comb begin
    mag_a_s = (sign_i & a_i[WIDTH-1]) ? (~a_i + {{(WIDTH-1){1'b0}}, 1'b1}) : a_i;
    mag_b_s = (sign_i & b_i[WIDTH-1]) ? (~b_i + {{(WIDTH-1){1'b0}}, 1'b1}) : b_i;
  end

  always_comb begin
    acc_step_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  end

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    if (start_i) begin
      cnt_d    = {CNT_W{1'b0}};
      mcand_d  = {{WIDTH{1'b0}}, mag_a_s};
      mplier_d = mag_b_s;
      acc_d    = {(2*WIDTH){1'b0}};
      neg_d    = sign_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      sgn_d    = sign_i;
    end else if (busy_i) begin
      cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_step_s;
    end else begin
      cnt_d    = cnt_q;
    end
  end

  // Result taps the in-flight final step so the top can register it on the done edge.
  always_comb begin
    done_o    = busy_i & (cnt_q == CNT_W'(WIDTH - 1));
    prod_lo_s = acc_step_s[WIDTH-1:0];
    prod_o    = neg_q ? (~prod_lo_s + {{(WIDTH-1){1'b0}}, 1'b1}) : prod_lo_s;
    if (!sgn_q) begin
      ofl_o = |acc_step_s[2*WIDTH-1:WIDTH];
    end else if (neg_q) begin
      ofl_o = (|acc_step_s[2*WIDTH-1:WIDTH]) |
              (acc_step_s[WIDTH-1] & (|acc_step_s[WIDTH-2:0]));
    end else begin
      ofl_o = |acc_step_s[2*WIDTH-1:WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CNT_W{1'b0}};
      mcand_q  <= {(2*WIDTH){1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      neg_q    <= 1'b0;
      sgn_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      sgn_q    <= sgn_d;
    end
  end

endmodule

// File: rtl/alu_seq_nb.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle logic and
// add/sub ops, plus a multi-cycle multiply that holds off new input while running.
module alu_seq_nb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             cin,
  input  logic             sign,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ofl,
  output logic             c_out,
  output logic             zero,
  output logic             err
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ofl_q, ofl_d, c_out_q, c_out_d, zero_q, zero_d, err_q, err_d;

  logic             accept_s, pop_s, mul_start_s, mul_busy_s, mul_done_s, mul_ofl_s;
  logic [WIDTH-1:0] mul_prod_s;
  logic [WIDTH-1:0] b_eff_s, alu_res_s;
  logic [WIDTH:0]   sum_s;
  logic             c_in_s, sgn_ofl_s, alu_ofl_s, alu_c_s, alu_err_s;

  always_comb begin
    in_ready   = (state_q == S_IDLE) & (~out_valid_q | out_ready);
    accept_s   = in_valid & in_ready;
    pop_s      = out_valid_q & out_ready;
    mul_busy_s = (state_q == S_MUL);
  end

  // Shared adder: SUB is A + ~B + 1, so carry-out means "no borrow".
  always_comb begin
    if (op == OP_SUB) begin
      b_eff_s = ~in_b;
      c_in_s  = 1'b1;
    end else begin
      b_eff_s = in_b;
      c_in_s  = cin;
    end
    sum_s     = {1'b0, in_a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, c_in_s};
    sgn_ofl_s = (in_a[WIDTH-1] == b_eff_s[WIDTH-1]) & (sum_s[WIDTH-1] != in_a[WIDTH-1]);
  end

  always_comb begin
    alu_res_s = sum_s[WIDTH-1:0];
    alu_ofl_s = 1'b0;
    alu_c_s   = 1'b0;
    alu_err_s = 1'b0;
    case (op)
      OP_ADD: begin
        alu_c_s   = sum_s[WIDTH];
        alu_ofl_s = sign ? sgn_ofl_s : sum_s[WIDTH];
      end
      OP_SUB: begin
        alu_c_s   = sum_s[WIDTH];
        alu_ofl_s = sign ? sgn_ofl_s : ~sum_s[WIDTH];
      end
      OP_AND:  alu_res_s = in_a & in_b;
      OP_OR:   alu_res_s = in_a | in_b;
      OP_XOR:  alu_res_s = in_a ^ in_b;
      OP_MUL:  alu_res_s = {WIDTH{1'b0}};
      default: begin
        alu_res_s = ILLEGAL_FILL[WIDTH-1:0];
        alu_err_s = 1'b1;
      end
    endcase
  end

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start_s),
    .busy_i  (mul_busy_s),
    .a_i     (in_a),
    .b_i     (in_b),
    .sign_i  (sign),
    .done_o  (mul_done_s),
    .prod_o  (mul_prod_s),
    .ofl_o   (mul_ofl_s)
  );

  // A MUL accept always frees the result slot, so completion never has to stall.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    ofl_d       = ofl_q;
    c_out_d     = c_out_q;
    err_d       = err_q;
    mul_start_s = 1'b0;
    out_valid_d = pop_s ? 1'b0 : out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (op == OP_MUL)) begin
          state_d     = S_MUL;
          mul_start_s = 1'b1;
          out_valid_d = 1'b0;
        end else if (accept_s) begin
          out_d       = alu_res_s;
          ofl_d       = alu_ofl_s;
          c_out_d     = alu_c_s;
          err_d       = alu_err_s;
          out_valid_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_done_s) begin
          state_d     = S_IDLE;
          out_d       = mul_prod_s;
          ofl_d       = mul_ofl_s;
          c_out_d     = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          state_d = S_MUL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    zero_d = (out_d == {WIDTH{1'b0}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_q       <= {WIDTH{1'b0}};
      ofl_q       <= 1'b0;
      c_out_q     <= 1'b0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ofl_q       <= ofl_d;
      c_out_q     <= c_out_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    out       = out_q;
    ofl       = ofl_q;
    c_out     = c_out_q;
    zero      = zero_q;
    err       = err_q;
  end

endmodule
